// File: rtl/spi_proto_pkg.sv
// Shared SPI protocol definitions: record IDs (common with the command decoder),
// frame constants and the status-encoder state encoding.
package spi_proto_pkg;

  localparam logic [7:0] IdKp        = 8'h01;
  localparam logic [7:0] IdKi        = 8'h02;
  localparam logic [7:0] IdKd        = 8'h03;
  localparam logic [7:0] IdVolume    = 8'h04;
  localparam logic [7:0] IdThreshold = 8'h06;
  localparam logic [7:0] IdMute      = 8'h07;
  localparam logic [7:0] IdFocus     = 8'h10;
  localparam logic [7:0] IdPidOut    = 8'h20;
  localparam logic [7:0] IdStatus    = 8'h21;

  localparam int unsigned NUM_RECORDS       = 9;
  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

  // XOR of every record ID; folded into the checksum as a constant.
  localparam logic [7:0] ID_XOR = IdKp ^ IdKi ^ IdKd ^ IdVolume ^ IdThreshold ^ IdMute ^
                                  IdFocus ^ IdPidOut ^ IdStatus;

  typedef logic [2:0] enc_state_t;

  localparam enc_state_t StIdle = 3'd0;
  localparam enc_state_t StSync = 3'd1;
  localparam enc_state_t StId   = 3'd2;
  localparam enc_state_t StHi   = 3'd3;
  localparam enc_state_t StLo   = 3'd4;
  localparam enc_state_t StCsum = 3'd5;

  function automatic logic [7:0] fold16(input logic [15:0] v);
    return v[15:8] ^ v[7:0];
  endfunction

endpackage

// File: rtl/telemetry_tick_gen.sv
// Free-running 0..PERIOD-1 counter producing a one-cycle tick at PERIOD-1.
// PERIOD=0 disables the tick entirely.
module telemetry_tick_gen #(
  parameter int unsigned PERIOD = 0
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned Last = (PERIOD == 0) ? 0 : PERIOD - 1;
  localparam int unsigned CntW = (Last > 0) ? $clog2(Last + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  assign wrap  = (cnt_q == CntW'(Last));
  assign tick  = (PERIOD != 0) && wrap;
  assign cnt_d = wrap ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_status_encoder.sv
// Snapshots control registers and loop telemetry on a trigger and streams them
// as a framed [sync, 9 x (id, hi, lo), checksum] byte sequence on Avalon-ST.
module spi_status_encoder
  import spi_proto_pkg::*;
#(
  parameter int unsigned PERIOD    = 0,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] kp,
  input  logic [15:0] ki,
  input  logic [15:0] kd,
  input  logic [15:0] threshold,
  input  logic [15:0] focus_signal,
  input  logic [7:0]  volume,
  input  logic        mute,
  input  logic [15:0] pid_out,
  input  logic [7:0]  status,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  localparam logic [3:0] LastIdx = 4'(NUM_RECORDS - 1);

  enc_state_t  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] kp_q, ki_q, kd_q, thr_q, focus_q, pid_q;
  logic [7:0]  vol_q, status_q;
  logic        mute_q;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        tick, trig, accept;
  logic [7:0]  rec_id, csum;
  logic [15:0] rec_data;

  telemetry_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // start and a period tick in the same cycle collapse into one trigger.
  assign trig   = start | tick;
  assign accept = trig && (state_q == StIdle);

  assign out_valid  = (state_q != StIdle);
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign drop_cnt   = drop_cnt_q;

  always_comb begin
    rec_id   = 8'h00;
    rec_data = 16'h0000;
    unique case (idx_q)
      4'd0:    begin rec_id = IdKp;        rec_data = kp_q;                 end
      4'd1:    begin rec_id = IdKi;        rec_data = ki_q;                 end
      4'd2:    begin rec_id = IdKd;        rec_data = kd_q;                 end
      4'd3:    begin rec_id = IdVolume;    rec_data = {8'h00, vol_q};       end
      4'd4:    begin rec_id = IdThreshold; rec_data = thr_q;                end
      4'd5:    begin rec_id = IdMute;      rec_data = {15'b0, mute_q};      end
      4'd6:    begin rec_id = IdFocus;     rec_data = focus_q;              end
      4'd7:    begin rec_id = IdPidOut;    rec_data = pid_q;                end
      4'd8:    begin rec_id = IdStatus;    rec_data = {8'h00, status_q};    end
      default: begin rec_id = 8'h00;       rec_data = 16'h0000;             end
    endcase
  end

  // Checksum depends only on the frozen shadows, so it is formed directly.
  assign csum = ID_XOR ^ fold16(kp_q) ^ fold16(ki_q) ^ fold16(kd_q) ^ vol_q ^
                fold16(thr_q) ^ {7'b0, mute_q} ^ fold16(focus_q) ^ fold16(pid_q) ^ status_q;

  always_comb begin
    out_data = 8'h00;
    unique case (state_q)
      StSync:  out_data = SYNC_BYTE;
      StId:    out_data = rec_id;
      StHi:    out_data = rec_data[15:8];
      StLo:    out_data = rec_data[7:0];
      StCsum:  out_data = csum;
      default: out_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: if (trig) begin
        state_d = StSync;
        idx_d   = 4'd0;
      end
      StSync: if (out_ready) state_d = StId;
      StId:   if (out_ready) state_d = StHi;
      StHi:   if (out_ready) state_d = StLo;
      StLo: if (out_ready) begin
        if (idx_q < LastIdx) begin
          state_d = StId;
          idx_d   = idx_q + 4'd1;
        end else begin
          state_d = StCsum;
        end
      end
      StCsum:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign frame_done_d = (state_q == StCsum) && out_ready;
  assign drop_cnt_d   = (trig && busy && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1
                                                                 : drop_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= 4'd0;
      frame_done_q <= 1'b0;
      drop_cnt_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kp_q     <= '0;
      ki_q     <= '0;
      kd_q     <= '0;
      thr_q    <= '0;
      focus_q  <= '0;
      pid_q    <= '0;
      vol_q    <= '0;
      status_q <= '0;
      mute_q   <= 1'b0;
    end else if (accept) begin
      kp_q     <= kp;
      ki_q     <= ki;
      kd_q     <= kd;
      thr_q    <= threshold;
      focus_q  <= focus_signal;
      pid_q    <= pid_out;
      vol_q    <= volume;
      status_q <= status;
      mute_q   <= mute;
    end
  end

endmodule

// File: tb/tb_spi_status_encoder.sv
// Directed bench: instance A (start only), B (PERIOD=40, drop counting) and
// C (PERIOD=64, auto-trigger) share one clock.
module tb_spi_status_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A
  logic        rst_a_n, st_a, rdy_a, mute_a;
  logic [15:0] kp_a, ki_a, kd_a, thr_a, foc_a, pid_a;
  logic [7:0]  vol_a, stat_a, od_a, dc_a;
  logic        ov_a, busy_a, fd_a;
  // Instances B and C
  logic        rst_b_n, st_b, rdy_b, ov_b, busy_b, fd_b;
  logic [7:0]  od_b, dc_b;
  logic        rst_c_n, st_c, rdy_c, ov_c, busy_c, fd_c;
  logic [7:0]  od_c, dc_c;
  logic [15:0] z16;
  logic [7:0]  z8;
  logic        z1;

  logic [7:0] exp_frame [29];
  logic [7:0] basic_exp [29];

  spi_status_encoder #(.PERIOD(0)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .start(st_a), .kp(kp_a), .ki(ki_a), .kd(kd_a),
    .threshold(thr_a), .focus_signal(foc_a), .volume(vol_a), .mute(mute_a), .pid_out(pid_a),
    .status(stat_a), .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a), .busy(busy_a),
    .frame_done(fd_a), .drop_cnt(dc_a)
  );

  spi_status_encoder #(.PERIOD(40)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .start(st_b), .kp(z16), .ki(z16), .kd(z16),
    .threshold(z16), .focus_signal(z16), .volume(z8), .mute(z1), .pid_out(z16),
    .status(z8), .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b), .busy(busy_b),
    .frame_done(fd_b), .drop_cnt(dc_b)
  );

  spi_status_encoder #(.PERIOD(64)) dut_c (
    .clk(clk), .reset_n(rst_c_n), .start(st_c), .kp(z16), .ki(z16), .kd(z16),
    .threshold(z16), .focus_signal(z16), .volume(z8), .mute(z1), .pid_out(z16),
    .status(z8), .out_data(od_c), .out_valid(ov_c), .out_ready(rdy_c), .busy(busy_c),
    .frame_done(fd_c), .drop_cnt(dc_c)
  );

  task automatic build_expected();
    logic [7:0]  ids [9];
    logic [15:0] dat [9];
    logic [7:0]  x;
    ids = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h10, 8'h20, 8'h21};
    dat = '{kp_a, ki_a, kd_a, {8'h00, vol_a}, thr_a, {15'b0, mute_a}, foc_a, pid_a,
            {8'h00, stat_a}};
    exp_frame[0] = 8'hA5;
    x = 8'h00;
    for (int r = 0; r < 9; r++) begin
      exp_frame[1 + 3*r] = ids[r];
      exp_frame[2 + 3*r] = dat[r][15:8];
      exp_frame[3 + 3*r] = dat[r][7:0];
      x = x ^ ids[r] ^ dat[r][15:8] ^ dat[r][7:0];
    end
    exp_frame[28] = x;
  endtask

  task automatic clear_inputs_a();
    kp_a = '0; ki_a = '0; kd_a = '0; thr_a = '0; foc_a = '0; pid_a = '0;
    vol_a = '0; stat_a = '0; mute_a = 1'b0;
  endtask

  // Leaves the caller #1 after the edge that accepted start.
  task automatic pulse_start_a(input bit hold_kp, input logic [15:0] new_kp);
    @(posedge clk); #1 st_a = 1'b1;
    @(posedge clk); #1 st_a = 1'b0;
    if (hold_kp) kp_a = new_kp;
  endtask

  task automatic collect_a(input bit rand_ready, input string tag);
    int n = 0, cyc = 0, done_seen = 0;
    logic stalled = 1'b0;
    logic [7:0] held = 8'h00;
    rdy_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while (n < 29 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (fd_a) done_seen++;
      if (stalled) begin
        n_vec++;
        if (od_a !== held) begin
          n_err++;
          $display("FAIL %s stall_hold byte %0d got=%h want=%h", tag, n, od_a, held);
        end
      end
      if (ov_a && rdy_a) begin
        n_vec++;
        if (od_a !== exp_frame[n]) begin
          n_err++;
          $display("FAIL %s byte%0d got=%h want=%h", tag, n, od_a, exp_frame[n]);
        end
        n++;
        stalled = 1'b0;
      end else if (ov_a) begin
        stalled = 1'b1;
        held = od_a;
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
      rdy_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    n_vec++;
    if (n != 29) begin
      n_err++;
      $display("FAIL %s byte_count got=%0d want=29", tag, n);
    end
    rdy_a = 1'b1;
    @(negedge clk);
    n_vec++;
    if (fd_a !== 1'b1 || busy_a !== 1'b0 || done_seen != 0) begin
      n_err++;
      $display("FAIL %s frame_end got fd=%b busy=%b early=%0d want fd=1 busy=0 early=0",
               tag, fd_a, busy_a, done_seen);
    end
    @(negedge clk);
    n_vec++;
    if (fd_a !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse_width got=%b want=0", tag, fd_a);
    end
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    z16 = '0; z8 = '0; z1 = 1'b0;
    clear_inputs_a();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({od_a, ov_a, busy_a, fd_a, dc_a} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_a got data=%h v=%b b=%b fd=%b dc=%h want all 0",
               od_a, ov_a, busy_a, fd_a, dc_a);
    end
    n_vec++;
    if ({ov_b, ov_c, dc_b, dc_c} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_bc got vb=%b vc=%b dcb=%h dcc=%h want 0", ov_b, ov_c, dc_b, dc_c);
    end
    @(posedge clk); #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_inputs_a();
    kp_a = 16'h1234;
    basic_exp = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00,
                  8'h04, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h10,
                  8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h21, 8'h00, 8'h00, 8'h32};
    exp_frame = basic_exp;
    @(negedge clk);
    n_vec++;
    if (ov_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle got v=%b b=%b want 0 0", ov_a, busy_a);
    end
    pulse_start_a(1'b0, 16'h0000);
    n_vec++;
    if (busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL basic_busy_latency got=%b want=1", busy_a);
    end
    collect_a(1'b0, "basic");
  endtask

  task automatic test_backpressure();
    exp_frame = basic_exp;
    pulse_start_a(1'b0, 16'h0000);
    collect_a(1'b1, "backpressure");
  endtask

  task automatic test_snapshot();
    exp_frame = basic_exp;
    kp_a = 16'h1234;
    pulse_start_a(1'b1, 16'hBEEF);
    collect_a(1'b0, "snapshot_first");
    build_expected();
    n_vec++;
    if (exp_frame[2] !== 8'hBE || exp_frame[28] !== 8'h45) begin
      n_err++;
      $display("FAIL snapshot_model got hi=%h cs=%h want BE 45", exp_frame[2], exp_frame[28]);
    end
    pulse_start_a(1'b0, 16'h0000);
    collect_a(1'b0, "snapshot_second");
  endtask

  task automatic test_all_fields();
    kp_a = 16'h1234; ki_a = 16'hABCD; kd_a = 16'h0102; vol_a = 8'h7F; thr_a = 16'h8000;
    mute_a = 1'b1; foc_a = 16'h5555; pid_a = 16'hFFFF; stat_a = 8'hC3;
    build_expected();
    pulse_start_a(1'b0, 16'h0000);
    clear_inputs_a();
    collect_a(1'b1, "all_fields");
  endtask

  task automatic test_busy_drop();
    logic prev;
    int cyc = 0;
    bit found = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dc_b !== 8'd0) begin
      n_err++;
      $display("FAIL drop_initial got=%0d want=0", dc_b);
    end
    prev = ov_b;
    while (!found && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ov_b && !prev) found = 1'b1;
      prev = ov_b;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL drop_auto_frame got=none want=frame within 200 cycles");
    end
    // Tick-started frame began at edge E; next tick lands at E+40.
    repeat (34) @(posedge clk);
    #1 st_b = 1'b1;
    @(posedge clk); #1 st_b = 1'b0;
    n_vec++;
    if (ov_b !== 1'b1 || od_b !== 8'hA5) begin
      n_err++;
      $display("FAIL drop_frame_start got v=%b d=%h want 1 A5", ov_b, od_b);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(posedge clk);
      #1 st_b = 1'b1;
      @(posedge clk); #1 st_b = 1'b0;
    end
    repeat (13) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (fd_b !== 1'b0 || ov_b !== 1'b1 || od_b !== 8'h14) begin
      n_err++;
      $display("FAIL drop_csum got fd=%b v=%b d=%h want 0 1 14", fd_b, ov_b, od_b);
    end
    @(negedge clk);
    n_vec++;
    if (fd_b !== 1'b1 || busy_b !== 1'b0 || dc_b !== 8'd3) begin
      n_err++;
      $display("FAIL drop_count got fd=%b busy=%b dc=%0d want 1 0 3", fd_b, busy_b, dc_b);
    end
  endtask

  task automatic test_auto();
    int rises = 0, cyc = 0, last = 0;
    logic prev;
    @(negedge clk);
    prev = ov_c;
    while (rises < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ov_c && !prev) begin
        n_vec++;
        if (od_c !== 8'hA5) begin
          n_err++;
          $display("FAIL auto_sync got=%h want=A5", od_c);
        end
        if (rises > 0) begin
          n_vec++;
          if (cyc - last != 64) begin
            n_err++;
            $display("FAIL auto_interval got=%0d want=64", cyc - last);
          end
        end
        last = cyc;
        rises++;
      end
      prev = ov_c;
    end
    n_vec++;
    if (rises != 4 || dc_c !== 8'd0) begin
      n_err++;
      $display("FAIL auto_summary got rises=%0d dc=%0d want 4 0", rises, dc_c);
    end
  endtask

  task automatic test_saturation();
    rdy_a = 1'b0;
    @(posedge clk); #1 st_a = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (dc_a !== 8'd10) begin
      n_err++;
      $display("FAIL sat_partial got=%0d want=10", dc_a);
    end
    repeat (290) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (dc_a !== 8'd255 || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL sat_cap got dc=%0d busy=%b want 255 1", dc_a, busy_a);
    end
    @(posedge clk); #1 st_a = 1'b0; rdy_a = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1 rst_a_n = 1'b0;
    @(posedge clk); #1 rst_a_n = 1'b1;
    clear_inputs_a();
    kp_a = 16'h1234;
    exp_frame = basic_exp;
    rdy_a = 1'b1;
    pulse_start_a(1'b0, 16'h0000);
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (ov_a !== 1'b1 || od_a !== exp_frame[10]) begin
      n_err++;
      $display("FAIL rmf_byte10 got v=%b d=%h want 1 %h", ov_a, od_a, exp_frame[10]);
    end
    rst_a_n = 1'b0;
    #1;
    n_vec++;
    if ({od_a, ov_a, busy_a, fd_a, dc_a} !== 19'd0) begin
      n_err++;
      $display("FAIL rmf_async got data=%h v=%b b=%b fd=%b dc=%h want all 0",
               od_a, ov_a, busy_a, fd_a, dc_a);
    end
    @(posedge clk); #1 rst_a_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (fd_a !== 1'b0 || ov_a !== 1'b0) begin
      n_err++;
      $display("FAIL rmf_no_done got fd=%b v=%b want 0 0", fd_a, ov_a);
    end
    pulse_start_a(1'b0, 16'h0000);
    collect_a(1'b0, "rmf_restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_all_fields();
    test_busy_drop();
    test_auto();
    test_saturation();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_status_encoder.md
# spi_status_encoder

Transmit-side counterpart of the SPI command path. It snapshots the live control register set plus loop telemetry and serializes it as a framed byte stream onto an Avalon-ST source that feeds the SPI slave TX FIFO, so the Teensy can read back the PID/volume settings and observe the loop. Records use the same `[id, hi, lo]` layout and the same ID codes as the command decoder.

## Interface
- `PERIOD`, default 0: auto-trigger interval in clk cycles; 0 disables auto-trigger, so frames are sent on `start` only.
- `SYNC_BYTE`, default 8'hA5: frame header byte.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  frame request pulse
- `kp`, `ki`, `kd`, `threshold`, `focus_signal`  in  16 each  register readback
- `volume`  in  8  volume readback
- `mute`  in  1  mute readback
- `pid_out`  in  16  PID controller output
- `status`  in  8  status flags
- `out_data`  out  8  stream byte
- `out_valid`  out  1  byte valid
- `out_ready`  in  1  sink ready
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse after the last byte is accepted
- `drop_cnt`  out  8  saturating count of dropped triggers

## Operation
- **Trigger:** `start`, or a period tick when `PERIOD` is nonzero.
- **Accepted trigger:** a trigger in IDLE is accepted. On that same clock edge, all inputs are latched into shadow registers. No further input sampling occurs until the next accepted trigger.
- **Frame layout:** `SYNC_BYTE`, then 9 records of `[id, hi, lo]`, then the checksum. Total 29 bytes.
- **Record order and contents:**
  - 01 kp
  - 02 ki
  - 03 kd
  - 04 {8'h00, volume}
  - 06 threshold
  - 07 {15'b0, mute}
  - 10 focus_signal
  - 20 pid_out
  - 21 {8'h00, status}
- **Checksum:** XOR of all 27 record bytes. The sync byte is excluded.
- **States:** IDLE → SYNC → ID → HI → LO.
  - After LO: go to ID if record index < 8, otherwise go to CSUM.
  - CSUM → IDLE.
  - Record index runs 0..8 and increments on LO acceptance.
- **Handshake:** a byte transfers on a cycle where `out_valid && out_ready`. While `out_valid=1` and `out_ready=0`, `out_data` holds stable. `out_valid` never drops mid-frame except on reset.
- **Dropped triggers:** a trigger while `busy=1` is dropped, and `drop_cnt` increments. It saturates at 255 and is cleared only by reset.
- **Simultaneous triggers:** `start` and a period tick in the same cycle count as one trigger. If busy, `drop_cnt` increments by 1 only.
- **Period counter:** free-runs 0..PERIOD-1 and ticks when it reaches PERIOD-1, independent of `busy`.
- **Reset values:**
  - Outputs: `out_data`=0, `out_valid`=0, `busy`=0, `frame_done`=0, `drop_cnt`=0.
  - Internal: state IDLE, shadow registers 0, period counter 0.
- **Reset mid-frame:** `out_valid` deasserts immediately (asynchronous). The partial frame is abandoned, with no checksum and no `frame_done`.

## Timing
- **Start latency:** trigger in cycle t (IDLE) gives `out_valid=1` and `out_data=SYNC_BYTE` in cycle t+1. `busy=1` from t+1.
- **Throughput:** with `out_ready` held high, one byte per cycle. Checksum is presented at t+29.
- **Frame end:** checksum accepted at cycle c → `frame_done=1`, `busy=0`, state IDLE at c+1.
- **Back-to-back frames:** a trigger at c+1 is accepted, so the minimum trigger spacing is 30 cycles.
- **Stalls:** backpressure stretches the frame. It never reorders, duplicates or skips bytes.

## Structure
- Shared package `spi_proto_pkg` holds:
  - Record ID constants (01, 02, 03, 04, 06, 07, 10, 20, 21), shared with the command decoder.
  - `NUM_RECORDS`=9.
  - Default `SYNC_BYTE`.
  - Encoder state enum.
- One sub-module, `telemetry_tick_gen`, contains the `PERIOD` counter and outputs `tick`. With `PERIOD=0` it ties `tick` to 0.
- The record mux (index → id/hi/lo) is combinational inside the top module.

## Test plan
- **Basic frame:** all inputs 0 except kp=16'h1234; pulse `start`, `out_ready`=1.
  - Expected bytes: A5 01 12 34 02 00 00 03 00 00 04 00 00 06 00 00 07 00 00 10 00 00 20 00 00 21 00 00 32.
  - `frame_done` pulses one cycle after the 32 is accepted.
- **Backpressure:** same stimulus; toggle `out_ready` randomly at 50% duty.
  - Identical 29-byte sequence.
  - `out_data` stable whenever `valid && !ready`.
- **Snapshot hold:** change kp to 16'hBEEF in the cycle after `start`.
  - Frame still carries 12 34.
  - The next frame carries BE EF.
- **Busy drop:** pulse `start` 3 times during a frame, once coincident with a tick (`PERIOD`=40).
  - `drop_cnt`=3.
  - No frame restart.
  - Saturation check: 300 drops → `drop_cnt`=255.
- **Auto-trigger:** `PERIOD`=64, `start`=0, `out_ready`=1.
  - SYNC bytes appear exactly 64 cycles apart.
  - `drop_cnt`=0.
- **Reset mid-frame:** assert `reset_n`=0 during byte 10.
  - `out_valid`=0 immediately; all outputs at reset values.
  - After release, `start` yields a complete, correct 29-byte frame.
